tcdm_beat_splitter: RTL and testbench
=====================================

TCDM_BEAT_SPLITTER -- requirements
Module: tcdm_beat_splitter

Interface
REQ-001 SHALL have parameter NB_PORTS, default 2, number of beat ports; power of two, 1..8.
REQ-002 SHALL have parameter TRANS_SID_WIDTH, default 1, transfer stream ID width.
REQ-003 SHALL have parameter TCDM_ADD_WIDTH, default 12, byte address width.
REQ-004 SHALL have parameter TCDM_OPC_WIDTH, default 12, opcode width.
REQ-005 SHALL have parameter MCHAN_LEN_WIDTH, default 15, byte length width.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1: single clock.
- rst_ni, in, 1: reset; synchronous, active-low.
- cmd_sid_i, in, TRANS_SID_WIDTH: command stream ID.
- cmd_add_i, in, TCDM_ADD_WIDTH: start byte address A.
- cmd_opc_i, in, TCDM_OPC_WIDTH: opcode, passed through.
- cmd_len_i, in, MCHAN_LEN_WIDTH: byte count L.
- cmd_req_i, in, 1: command valid.
- cmd_gnt_o, out, 1: command accepted.
- beat_req_o, out, NB_PORTS: per-port beat valid.
- beat_add_o, out, NB_PORTS x TCDM_ADD_WIDTH: word-aligned byte address.
- beat_be_o, out, NB_PORTS x 4: byte enables.
- beat_opc_o, out, NB_PORTS x TCDM_OPC_WIDTH: opcode copy.
- beat_sid_o, out, NB_PORTS x TRANS_SID_WIDTH: stream ID copy.
- beat_eop_o, out, NB_PORTS: last beat of the command on this port.
- beat_gnt_i, in, NB_PORTS: per-port beat accept.
- busy_o, out, 1: a command is being split.

Function
REQ-007 SHALL implement FSM IDLE/ISSUE; cmd_gnt_o=1 only in IDLE; handshake cmd_req_i&cmd_gnt_o latches A, L, opc, sid and moves to ISSUE.
REQ-008 SHALL present the first beats in the cycle after acceptance; beat outputs SHALL be driven from registered state only (no combinational cmd_* -> beat_* path).
REQ-009 SHALL map word W=A>>2 (and successors) to port W mod NB_PORTS; a row is the NB_PORTS words sharing W/NB_PORTS; one row is presented at a time, in ascending order.
REQ-010 SHALL assert beat_req_o[p] in a row only for ports holding a covered word, plus dummy beats per REQ-014; beat_add_o[p] = word address of port p in the current row.
REQ-011 SHALL hold a presented port's signals stable until beat_gnt_i[p]; after that handshake the port's req SHALL be low from the next cycle until the row advances; the row SHALL advance the cycle after the last pending port handshakes.
REQ-012 SHALL set beat_be_o: 4'hF for interior words; the first word masks bytes below A[1:0]; the last word (byte A+L-1) masks bytes above (A+L-1)[1:0]; both masks SHALL be ANDed when first==last.
REQ-013 SHALL assert beat_eop_o[p] on each port's last real beat: in the final row for p <= last_word mod NB_PORTS, and in the preceding row otherwise.
REQ-014 SHALL, for every port with no real beat in the whole command, issue one dummy beat in the final row with be=0, eop=1, address = that port's word in the final row; L=0 SHALL therefore produce one dummy beat on every port in A's row.
REQ-015 SHALL compute all address arithmetic modulo 2^TCDM_ADD_WIDTH; rows wrap from the top address to 0 without error.
REQ-016 SHALL return to IDLE the cycle after the final row completes; one idle bubble between commands is required.
REQ-017 SHALL replicate the latched opc and sid on every presented port; busy_o=1 exactly in ISSUE.
REQ-018 SHALL ignore beat_gnt_i on ports whose req is low.

Reset
REQ-019 SHALL on rst_ni=0 at a clock edge enter IDLE, clear row and done state, and drive beat_req_o=0, beat_eop_o=0, beat_be_o=0, beat_add_o=0, busy_o=0, cmd_gnt_o=1 the following cycle, including mid-command; any partially issued command SHALL be discarded.

Structure
REQ-020 SHALL place NB_PORTS limits, the state enum and byte-enable mask constants in shared package tcdm_pkg.
REQ-021 SHALL use one combinational sub-module, tcdm_row_mask, producing per-port active/be/eop/dummy for the current row.

Verification
REQ-022 SHALL cover NB_PORTS=2, A=0x000, L=16, gnt all 1 -> port0 0x000,0x008 and port1 0x004,0x00C, be=F, eop on the second beats, cmd_gnt_o high 1 cycle after row 1.
REQ-023 SHALL cover A=0x003, L=2 -> single row: port0 0x000 be=8 eop, port1 0x004 be=1 eop.
REQ-024 SHALL cover A=0x004, L=4 -> port1 0x004 be=F eop; port0 dummy 0x000 be=0 eop, same row.
REQ-025 SHALL cover L=0, A=0x010 -> dummies on port0 0x010 and port1 0x014, be=0, eop=1, then IDLE.
REQ-026 SHALL cover A=0xFF8, L=16 with port1 gnt low 3 cycles -> port0 req drops after its gnt, row held; beats 0xFF8/0xFFC, then 0x000/0x004 with eop.
REQ-027 SHALL cover rst_ni low during row 1 of REQ-022 -> all req low the next cycle, cmd_gnt_o=1, new command accepted normally.

Source files
------------

// File: rtl/tcdm_pkg.sv
// -----------------------------------------------------------------------------
// tcdm_pkg
// Shared definitions for the TCDM beat splitter:
//   - limits on the number of beat ports
//   - splitter FSM state encoding
//   - byte-enable mask constants and helpers for the first/last word of a
//     command
// No ports; imported by tcdm_row_mask and tcdm_beat_splitter.
// -----------------------------------------------------------------------------
package tcdm_pkg;

    // The number of beat ports must be a power of two in this range.
    localparam int unsigned TCDM_MIN_PORTS = 1;
    localparam int unsigned TCDM_MAX_PORTS = 8;

    // Every beat carries one 32-bit word, so there are four byte enables.
    localparam int unsigned TCDM_BE_WIDTH = 4;

    localparam logic [TCDM_BE_WIDTH-1:0] BE_FULL = 4'hF;
    localparam logic [TCDM_BE_WIDTH-1:0] BE_NONE = 4'h0;

    typedef enum logic {
        SPLIT_IDLE  = 1'b0,
        SPLIT_ISSUE = 1'b1
    } split_state_e;

    // First word of a command: keep bytes at or above the start offset.
    function automatic logic [TCDM_BE_WIDTH-1:0] be_first_mask(input logic [1:0] off);
        return BE_FULL << off;
    endfunction

    // Last word of a command: keep bytes at or below the end offset.
    function automatic logic [TCDM_BE_WIDTH-1:0] be_last_mask(input logic [1:0] off);
        return BE_FULL >> (2'd3 - off);
    endfunction

endpackage

// File: rtl/tcdm_row_mask.sv
// -----------------------------------------------------------------------------
// tcdm_row_mask
// Purely combinational decode of one row of a split command. For every beat
// port it reports whether the port takes part in the current row, the byte
// enables, whether this is the port's last real beat, and whether the beat is
// a dummy (a port that gets no real data anywhere in the command still
// receives one zero-enable beat in the final row so it sees an end-of-packet).
//
// Ports
//   first_row   : current row is the first row of the command
//   last_row    : current row is the final row of the command
//   penult_row  : current row is the one just before the final row
//   two_rows    : the command spans exactly two rows
//   len_zero    : the command has zero length (dummy beats only)
//   first_port  : port holding the first word of the command
//   last_port   : port holding the last word of the command
//   first_off   : byte offset of the first byte inside its word
//   last_off    : byte offset of the last byte inside its word
//   active      : port presents a beat (real or dummy) in this row
//   be          : byte enables for real beats, zero otherwise
//   eop         : port's last real beat of the command is in this row
//   dummy       : port presents a dummy beat in this row
// -----------------------------------------------------------------------------
module tcdm_row_mask
    import tcdm_pkg::*;
#(
    parameter int unsigned NB_PORTS = 2,
    parameter int unsigned PORT_W   = 1
) (
    input  logic                                   first_row,
    input  logic                                   last_row,
    input  logic                                   penult_row,
    input  logic                                   two_rows,
    input  logic                                   len_zero,
    input  logic [PORT_W-1:0]                      first_port,
    input  logic [PORT_W-1:0]                      last_port,
    input  logic [1:0]                             first_off,
    input  logic [1:0]                             last_off,
    output logic [NB_PORTS-1:0]                    active,
    output logic [NB_PORTS-1:0][TCDM_BE_WIDTH-1:0] be,
    output logic [NB_PORTS-1:0]                    eop,
    output logic [NB_PORTS-1:0]                    dummy
);

    logic single_row;

    assign single_row = first_row & last_row;

    for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
        localparam logic [PORT_W-1:0] P = PORT_W'(p);

        logic                     below_first;
        logic                     above_last;
        logic                     real_beat;
        logic                     no_real;
        logic [TCDM_BE_WIDTH-1:0] mask;

        assign below_first = (P < first_port);
        assign above_last  = (P > last_port);

        // Ports before the first word are skipped in the first row, ports
        // after the last word are skipped in the final row; all interior rows
        // are full.
        assign real_beat = !len_zero
                         && !(first_row && below_first)
                         && !(last_row && above_last);

        // A port has no data anywhere only when the command is shorter than
        // one full row: either it fits in one row and misses the port, or it
        // straddles two rows and the port falls in the gap between the tail
        // of the first row and the head of the second.
        assign no_real = len_zero
                       || (single_row && (below_first || above_last))
                       || (two_rows && below_first && above_last);

        assign mask = ((first_row && (P == first_port)) ? be_first_mask(first_off) : BE_FULL)
                    & ((last_row && (P == last_port)) ? be_last_mask(last_off) : BE_FULL);

        assign active[p] = real_beat | dummy[p];
        assign dummy[p]  = last_row & no_real;
        assign be[p]     = real_beat ? mask : BE_NONE;

        // Ports up to the last word's port finish in the final row; ports
        // beyond it saw their last word one row earlier.
        assign eop[p] = real_beat && ((last_row && !above_last) || (penult_row && above_last));
    end

endmodule

// File: rtl/tcdm_beat_splitter.sv
// -----------------------------------------------------------------------------
// tcdm_beat_splitter
// Splits a byte-granular command (start address A, length L) into word beats
// spread across NB_PORTS interleaved ports. Word W = A>>2 lives on port
// W mod NB_PORTS; the NB_PORTS words sharing W/NB_PORTS form a row. Rows are
// issued one at a time in ascending (wrapping) address order; a row advances
// the cycle after its last pending port handshakes. Ports without any real
// data get one zero-enable dummy beat with eop in the final row.
//
// Ports
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset
//   cmd_sid_i   : command stream ID, copied onto every beat
//   cmd_add_i   : start byte address A
//   cmd_opc_i   : opcode, copied onto every beat
//   cmd_len_i   : byte count L
//   cmd_req_i   : command valid
//   cmd_gnt_o   : command accepted (high only while idle)
//   beat_req_o  : per-port beat valid
//   beat_add_o  : per-port word-aligned byte address
//   beat_be_o   : per-port byte enables
//   beat_opc_o  : per-port opcode copy
//   beat_sid_o  : per-port stream ID copy
//   beat_eop_o  : per-port last beat of the command
//   beat_gnt_i  : per-port beat accept
//   busy_o      : a command is being split
// -----------------------------------------------------------------------------
module tcdm_beat_splitter
    import tcdm_pkg::*;
#(
    parameter int unsigned NB_PORTS        = 2,
    parameter int unsigned TRANS_SID_WIDTH = 1,
    parameter int unsigned TCDM_ADD_WIDTH  = 12,
    parameter int unsigned TCDM_OPC_WIDTH  = 12,
    parameter int unsigned MCHAN_LEN_WIDTH = 15
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [TRANS_SID_WIDTH-1:0]               cmd_sid_i,
    input  logic [TCDM_ADD_WIDTH-1:0]                cmd_add_i,
    input  logic [TCDM_OPC_WIDTH-1:0]                cmd_opc_i,
    input  logic [MCHAN_LEN_WIDTH-1:0]               cmd_len_i,
    input  logic                                     cmd_req_i,
    output logic                                     cmd_gnt_o,
    output logic [NB_PORTS-1:0]                      beat_req_o,
    output logic [NB_PORTS-1:0][TCDM_ADD_WIDTH-1:0]  beat_add_o,
    output logic [NB_PORTS-1:0][TCDM_BE_WIDTH-1:0]   beat_be_o,
    output logic [NB_PORTS-1:0][TCDM_OPC_WIDTH-1:0]  beat_opc_o,
    output logic [NB_PORTS-1:0][TRANS_SID_WIDTH-1:0] beat_sid_o,
    output logic [NB_PORTS-1:0]                      beat_eop_o,
    input  logic [NB_PORTS-1:0]                      beat_gnt_i,
    output logic                                     busy_o
);

    localparam int unsigned LOG_NB = $clog2(NB_PORTS);
    localparam int unsigned PORT_W = (LOG_NB > 0) ? LOG_NB : 1;
    localparam int unsigned WORD_W = TCDM_ADD_WIDTH - 2;
    // Row counter is one bit wider than the length so that the row offset
    // plus the length can never overflow.
    localparam int unsigned CNT_W  = MCHAN_LEN_WIDTH + 1;

    localparam logic [WORD_W-1:0]         PORT_MASK     = WORD_W'(NB_PORTS - 1);
    localparam logic [WORD_W-1:0]         ROW_STEP      = WORD_W'(NB_PORTS);
    localparam logic [TCDM_ADD_WIDTH-1:0] ROW_BYTE_MASK = TCDM_ADD_WIDTH'(4 * NB_PORTS - 1);

    // ------------------------------------------------------------------
    // Command decode; feeds only the latch registers, never the beat ports.
    // ------------------------------------------------------------------
    logic [TCDM_ADD_WIDTH-1:0] cmd_end;
    logic [WORD_W-1:0]         cmd_first_word;
    logic [WORD_W-1:0]         cmd_last_word;
    logic [CNT_W-1:0]          cmd_row_off;
    logic [CNT_W-1:0]          cmd_span;
    logic [CNT_W-1:0]          cmd_rows_m1;
    logic                      cmd_len_zero;

    // NOTE: every signal of an always_comb gets a default at the top so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cmd_len_zero   = (cmd_len_i == '0);
        // Address of the last byte, wrapping modulo the address space.
        cmd_end        = cmd_add_i + TCDM_ADD_WIDTH'(cmd_len_i) - TCDM_ADD_WIDTH'(1);
        cmd_first_word = cmd_add_i[TCDM_ADD_WIDTH-1:2];
        cmd_last_word  = cmd_end[TCDM_ADD_WIDTH-1:2];
        // Row count comes from the offset inside the first row plus the
        // length, so it stays correct even when the addresses wrap.
        cmd_row_off    = CNT_W'(cmd_add_i & ROW_BYTE_MASK);
        cmd_span       = cmd_row_off + CNT_W'(cmd_len_i) - CNT_W'(1);
        cmd_rows_m1    = cmd_len_zero ? '0 : (cmd_span >> (LOG_NB + 2));
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    split_state_e state_q, state_d;

    logic [WORD_W-1:0]          row_word_q;    // word address of port 0 in the current row
    logic [CNT_W-1:0]           rows_left_q;   // rows still to issue after the current one
    logic                       first_row_q;
    logic                       two_rows_q;
    logic                       len_zero_q;
    logic [PORT_W-1:0]          first_port_q;
    logic [PORT_W-1:0]          last_port_q;
    logic [1:0]                 first_off_q;
    logic [1:0]                 last_off_q;
    logic [TCDM_OPC_WIDTH-1:0]  opc_q;
    logic [TRANS_SID_WIDTH-1:0] sid_q;
    logic [NB_PORTS-1:0]        done_q;        // ports already handshaken in this row

    logic                                  issuing;
    logic                                  cmd_accept;
    logic                                  last_row;
    logic                                  penult_row;
    logic                                  row_complete;
    logic [NB_PORTS-1:0]                   pending;
    logic [NB_PORTS-1:0]                   row_active;
    logic [NB_PORTS-1:0]                   row_eop;
    logic [NB_PORTS-1:0]                   row_dummy;
    logic [NB_PORTS-1:0][TCDM_BE_WIDTH-1:0] row_be;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SPLIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_gnt_o = 1'b0;
        busy_o    = 1'b0;
        unique case (state_q)
            SPLIT_IDLE: begin
                cmd_gnt_o = 1'b1;
                if (cmd_req_i) begin
                    state_d = SPLIT_ISSUE;
                end
            end
            SPLIT_ISSUE: begin
                busy_o = 1'b1;
                if (row_complete && last_row) begin
                    state_d = SPLIT_IDLE;
                end
            end
            default: state_d = SPLIT_IDLE;
        endcase
    end

    assign issuing    = (state_q == SPLIT_ISSUE);
    assign cmd_accept = cmd_req_i & cmd_gnt_o;
    assign last_row   = (rows_left_q == '0);
    assign penult_row = (rows_left_q == CNT_W'(1));

    // A port is pending while it takes part in the row and has not yet been
    // granted; grants on ports that are not pending are ignored.
    assign pending      = issuing ? (row_active & ~done_q) : '0;
    assign row_complete = issuing && ((pending & ~beat_gnt_i) == '0);

    // NOTE: the payload registers are reset along with the control state so
    // an aborted command leaves nothing behind that could leak into the next.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            row_word_q   <= '0;
            rows_left_q  <= '0;
            first_row_q  <= 1'b0;
            two_rows_q   <= 1'b0;
            len_zero_q   <= 1'b0;
            first_port_q <= '0;
            last_port_q  <= '0;
            first_off_q  <= '0;
            last_off_q   <= '0;
            opc_q        <= '0;
            sid_q        <= '0;
            done_q       <= '0;
        end else if (cmd_accept) begin
            row_word_q   <= cmd_first_word & ~PORT_MASK;
            rows_left_q  <= cmd_rows_m1;
            first_row_q  <= 1'b1;
            two_rows_q   <= (cmd_rows_m1 == CNT_W'(1));
            len_zero_q   <= cmd_len_zero;
            first_port_q <= PORT_W'(cmd_first_word & PORT_MASK);
            last_port_q  <= PORT_W'(cmd_last_word & PORT_MASK);
            first_off_q  <= cmd_add_i[1:0];
            last_off_q   <= cmd_end[1:0];
            opc_q        <= cmd_opc_i;
            sid_q        <= cmd_sid_i;
            done_q       <= '0;
        end else if (row_complete) begin
            // Row address wraps naturally at the top of the word space.
            row_word_q  <= row_word_q + ROW_STEP;
            rows_left_q <= rows_left_q - CNT_W'(1);
            first_row_q <= 1'b0;
            done_q      <= '0;
        end else begin
            done_q <= done_q | (pending & beat_gnt_i);
        end
    end

    // ------------------------------------------------------------------
    // Row decode
    // ------------------------------------------------------------------
    tcdm_row_mask #(
        .NB_PORTS (NB_PORTS),
        .PORT_W   (PORT_W)
    ) u_row_mask (
        .first_row  (first_row_q),
        .last_row   (last_row),
        .penult_row (penult_row),
        .two_rows   (two_rows_q),
        .len_zero   (len_zero_q),
        .first_port (first_port_q),
        .last_port  (last_port_q),
        .first_off  (first_off_q),
        .last_off   (last_off_q),
        .active     (row_active),
        .be         (row_be),
        .eop        (row_eop),
        .dummy      (row_dummy)
    );

    // ------------------------------------------------------------------
    // Beat outputs: registered state only, all zero while idle.
    // ------------------------------------------------------------------
    always_comb begin
        beat_req_o = pending;
        beat_eop_o = issuing ? (row_eop | row_dummy) : '0;
        beat_add_o = '0;
        beat_be_o  = '0;
        beat_opc_o = '0;
        beat_sid_o = '0;
        if (issuing) begin
            for (int p = 0; p < NB_PORTS; p++) begin
                beat_add_o[p] = {row_word_q + WORD_W'(p), 2'b00};
                beat_be_o[p]  = row_be[p];
                beat_opc_o[p] = opc_q;
                beat_sid_o[p] = sid_q;
            end
        end
    end

endmodule

// File: tb/tb_tcdm_beat_splitter.sv
// -----------------------------------------------------------------------------
// tb_tcdm_beat_splitter
// Self-checking bench for tcdm_beat_splitter with NB_PORTS=2. Expected beats
// are derived byte by byte from (A, L): every byte marks its word's enable
// bit, words are grouped per port and row, each port's last word carries eop,
// and ports left empty get one dummy beat in the final row. Each cycle the
// beats of the lowest outstanding row must be presented, and nothing else.
// -----------------------------------------------------------------------------
module tb_tcdm_beat_splitter;

    localparam int NB     = 2;
    localparam int AW     = 12;
    localparam int OW     = 12;
    localparam int SW     = 1;
    localparam int LW     = 15;
    localparam int BUDGET = 400;
    localparam int ASPACE = 1 << AW;

    typedef struct {
        int row;
        int add;
        int be;
        bit eop;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [SW-1:0]           cmd_sid = '0;
    logic [AW-1:0]           cmd_add = '0;
    logic [OW-1:0]           cmd_opc = '0;
    logic [LW-1:0]           cmd_len = '0;
    logic                    cmd_req = 1'b0;
    logic                    cmd_gnt;
    logic [NB-1:0]           beat_req;
    logic [NB-1:0][AW-1:0]   beat_add;
    logic [NB-1:0][3:0]      beat_be;
    logic [NB-1:0][OW-1:0]   beat_opc;
    logic [NB-1:0][SW-1:0]   beat_sid;
    logic [NB-1:0]           beat_eop;
    logic [NB-1:0]           beat_gnt = '0;
    logic                    busy;

    int n_checks = 0;
    int n_pass   = 0;

    beat_t exp_q[NB][$];

    always #5 clk = ~clk;

    tcdm_beat_splitter #(
        .NB_PORTS        (NB),
        .TRANS_SID_WIDTH (SW),
        .TCDM_ADD_WIDTH  (AW),
        .TCDM_OPC_WIDTH  (OW),
        .MCHAN_LEN_WIDTH (LW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_sid_i  (cmd_sid),
        .cmd_add_i  (cmd_add),
        .cmd_opc_i  (cmd_opc),
        .cmd_len_i  (cmd_len),
        .cmd_req_i  (cmd_req),
        .cmd_gnt_o  (cmd_gnt),
        .beat_req_o (beat_req),
        .beat_add_o (beat_add),
        .beat_be_o  (beat_be),
        .beat_opc_o (beat_opc),
        .beat_sid_o (beat_sid),
        .beat_eop_o (beat_eop),
        .beat_gnt_i (beat_gnt),
        .busy_o     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int queues_left();
        int n = 0;
        for (int p = 0; p < NB; p++) n += exp_q[p].size();
        return n;
    endfunction

    // Reference: walk the bytes of the command and collect words per port.
    task automatic build_model(input int a, input int len);
        int    first_word, last_word, base_word, final_row;
        int    byte_addr, rel, word, port, prev_rel, idx;
        beat_t e;
        for (int p = 0; p < NB; p++) exp_q[p].delete();
        first_word = a / 4;
        prev_rel   = -1;
        for (int b = 0; b < len; b++) begin
            byte_addr = (a + b) % ASPACE;
            rel       = ((a % 4) + b) / 4;
            word      = byte_addr / 4;
            port      = word % NB;
            if (rel != prev_rel) begin
                e.row = ((first_word % NB) + rel) / NB;
                e.add = word * 4;
                e.be  = 0;
                e.eop = 1'b0;
                exp_q[port].push_back(e);
                prev_rel = rel;
            end
            idx = exp_q[port].size() - 1;
            e = exp_q[port][idx];
            e.be = e.be | (1 << (byte_addr % 4));
            exp_q[port][idx] = e;
        end
        if (len == 0) begin
            last_word = first_word;
            final_row = 0;
        end else begin
            last_word = ((a + len - 1) % ASPACE) / 4;
            final_row = ((first_word % NB) + ((a % 4) + len - 1) / 4) / NB;
        end
        base_word = last_word - (last_word % NB);
        for (int p = 0; p < NB; p++) begin
            if (exp_q[p].size() == 0) begin
                e.row = final_row;
                e.add = ((base_word + p) * 4) % ASPACE;
                e.be  = 0;
                e.eop = 1'b1;
                exp_q[p].push_back(e);
            end else begin
                idx = exp_q[p].size() - 1;
                e = exp_q[p][idx];
                e.eop = 1'b1;
                exp_q[p][idx] = e;
            end
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cmd_req  = 1'b0;
        beat_gnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: grants always high; 1: random grants; 2: port 1 withheld 3 cycles
    task automatic run_cmd(input string name, input int a, input int len,
                           input int sid, input int opc, input int mode);
        int            cyc;
        int            min_row;
        logic [NB-1:0] g;
        beat_t         f;
        build_model(a, len);
        @(negedge clk);
        check({name, "_idle_gnt"}, cmd_gnt, 1);
        cmd_add = AW'(a);
        cmd_len = LW'(len);
        cmd_sid = SW'(sid);
        cmd_opc = OW'(opc);
        cmd_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0;
        cyc = 0;
        while (queues_left() != 0 && cyc < BUDGET) begin
            check($sformatf("%s_busy", name), busy, 1);
            check($sformatf("%s_cmd_gnt_low", name), cmd_gnt, 0);
            min_row = 1 << 30;
            for (int p = 0; p < NB; p++)
                if (exp_q[p].size() != 0 && exp_q[p][0].row < min_row) min_row = exp_q[p][0].row;
            for (int p = 0; p < NB; p++) begin
                if (exp_q[p].size() == 0) begin
                    check($sformatf("%s_p%0d_req_after_eop", name, p), beat_req[p], 0);
                end else begin
                    f = exp_q[p][0];
                    check($sformatf("%s_p%0d_req_c%0d", name, p, cyc), beat_req[p], (f.row == min_row));
                    if (beat_req[p]) begin
                        check($sformatf("%s_p%0d_add", name, p), beat_add[p], f.add);
                        check($sformatf("%s_p%0d_be", name, p), beat_be[p], f.be);
                        check($sformatf("%s_p%0d_eop", name, p), beat_eop[p], f.eop);
                        check($sformatf("%s_p%0d_sid", name, p), beat_sid[p], sid % (1 << SW));
                        check($sformatf("%s_p%0d_opc", name, p), beat_opc[p], opc % (1 << OW));
                    end
                end
            end
            case (mode)
                0:       g = '1;
                1:       for (int p = 0; p < NB; p++) g[p] = ($urandom_range(0, 99) < 60);
                default: begin g = '1; if (cyc < 3) g[1] = 1'b0; end
            endcase
            beat_gnt = g;
            for (int p = 0; p < NB; p++)
                if (beat_req[p] && g[p] && exp_q[p].size() != 0) f = exp_q[p].pop_front();
            @(negedge clk);
            cyc++;
        end
        beat_gnt = '0;
        check({name, "_beats_left"}, queues_left(), 0);
        check({name, "_end_busy"}, busy, 0);
        check({name, "_end_cmd_gnt"}, cmd_gnt, 1);
        check({name, "_end_req"}, beat_req, 0);
        if (queues_left() != 0) do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("reset_cmd_gnt", cmd_gnt, 1);
        check("reset_busy", busy, 0);
        check("reset_req", beat_req, 0);
        check("reset_eop", beat_eop, 0);
        check("reset_be", beat_be, 0);
        check("reset_add", beat_add, 0);

        run_cmd("aligned_two_rows", 'h000, 16, 1, 'h123, 0);
        run_cmd("single_row_partial", 'h003, 2, 0, 'h0A5, 0);
        run_cmd("dummy_port0", 'h004, 4, 1, 'h7FF, 0);
        run_cmd("zero_len", 'h010, 0, 0, 'h001, 0);
        run_cmd("wrap_held", 'hFF8, 16, 1, 'hABC, 2);

        // Reset in the middle of the first row of a two-row command.
        build_model('h000, 16);
        @(negedge clk);
        cmd_add = '0;
        cmd_len = LW'(16);
        cmd_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0;
        check("midrst_busy_before", busy, 1);
        check("midrst_req_before", beat_req, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_req", beat_req, 0);
        check("midrst_cmd_gnt", cmd_gnt, 1);
        check("midrst_busy", busy, 0);
        check("midrst_eop", beat_eop, 0);
        check("midrst_be", beat_be, 0);
        check("midrst_add", beat_add, 0);
        run_cmd("after_midrst", 'h020, 8, 1, 'h055, 0);

        for (int i = 0; i < 60; i++) begin
            int a, len, mode;
            a    = $urandom_range(0, ASPACE - 1);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(1, 48);
            mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
            run_cmd($sformatf("rnd%0d", i), a, len, $urandom_range(0, 1), $urandom_range(0, 4095), mode);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
